// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - shared types and constants for the gcd arbiter
package gcd_arb_pkg;

  localparam int GCD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gcd_arbiter_if.sv
// rtl/gcd_arbiter_if.sv - request, engine and response signals of the gcd arbiter
interface gcd_arbiter_if
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = GCD_W
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   eng_start;
  logic [WIDTH-1:0]       eng_a;
  logic [WIDTH-1:0]       eng_b;
  logic [WIDTH-1:0]       eng_result;
  logic                   eng_done;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_err;

  // Environment side: requesters, gcd engine and response consumer
  modport master (
    output req_valid, req_a, req_b, eng_result, eng_done, rsp_ready,
    input  req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, eng_result, eng_done, rsp_ready,
    output req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/gcd_arbiter_rr_pick.sv
// rtl/gcd_arbiter_rr_pick.sv - combinational round-robin picker (first request at or after ptr)
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  // Scan offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % N_REQ;
      if (((req >> k) & {{(N_REQ-1){1'b0}}, 1'b1}) != '0) begin
        grant = {{(N_REQ-1){1'b0}}, 1'b1} << k;
        idx   = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin sharing of one gcd engine; GCD_ARB_TIMEOUT_EN adds a BUSY watchdog
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = GCD_W,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input logic          clk,
  input logic          reset,
  gcd_arbiter_if.slave bus
);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, id_q, grant_idx;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] a_q, b_q, res_q, a_sel, b_sel;
  logic             take, bypass, timed_out;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Route the granted requester's operand slices
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign take   = (state == IDLE) && (|bus.req_valid);
  // The subtract/swap engine never terminates on a zero operand, so answer a|b locally
  assign bypass = (a_sel == '0) || (b_sel == '0);

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;

  // eng_done wins over the watchdog if both land in the same cycle
  assign timed_out = (state == BUSY) && !bus.eng_done &&
                     (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count BUSY cycles, flag the response that the timeout produced
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE)     busy_cnt <= '0;
      else if (state == BUSY) busy_cnt <= busy_cnt + 1'b1;
      if (take)           err_q <= 1'b0;
      else if (timed_out) err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign timed_out   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Next-state logic: one job in flight, new grants only from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = bypass ? RESP : ISSUE;
      ISSUE:   state_nxt = BUSY;
      BUSY:    if (bus.eng_done || timed_out) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Job registers: operands and id latched at grant, result at bypass/done/timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else if (take) begin
      a_q    <= a_sel;
      b_q    <= b_sel;
      id_q   <= grant_idx;
      rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      res_q  <= bypass ? (a_sel | b_sel) : '0;
    end else if ((state == BUSY) && bus.eng_done) begin
      res_q  <= bus.eng_result;
    end else if (timed_out) begin
      res_q  <= '0;
    end
  end

  // req_ready is combinational from the picker; masked so reset forces it low at once
  assign bus.req_ready  = ((state == IDLE) && !reset) ? grant : '0;
  assign bus.eng_start  = (state == ISSUE);
  assign bus.eng_a      = ((state == ISSUE) || (state == BUSY)) ? a_q : '0;
  assign bus.eng_b      = ((state == ISSUE) || (state == BUSY)) ? b_q : '0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;

endmodule
